// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 LSB-first UART receiver with a small receive FIFO behind a
//            16-bit CPU register interface (status at a0=0, data at a0=1).
//            Define UART_RX_FIFO_EN for a 4-entry FIFO; otherwise the FIFO is
//            a single holding register with the same status/overrun/pop rules.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DIVISOR = 32000000 / 115200
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [15:0] data,
    input  logic        a0,
    input  logic        rnw,
    input  logic        cs_b,
    input  logic        rxd
);

`ifdef UART_RX_FIFO_EN
    localparam int C_DEPTH = 4;
`else
    localparam int C_DEPTH = 1;
`endif
    localparam int       C_PTR_W = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
    localparam int       C_CNT_W = $clog2(C_DEPTH + 1);
    localparam int       C_MEM   = 1 << C_PTR_W;
    localparam bit [8:0] C_FULL  = 9'(DIVISOR - 1);
    localparam bit [8:0] C_HALF  = 9'(DIVISOR / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic               sync1_q, sync2_q;
    state_t             state_q, state_d;
    logic [8:0]         cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               rd_q, rd_d;
    logic               ovr_q, ovr_d;
    logic               frm_q, frm_d;
    logic [C_PTR_W-1:0] wptr_q, wptr_d;
    logic [C_PTR_W-1:0] rptr_q, rptr_d;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic [7:0]         mem_q [C_MEM];

    logic               w_rxd_s;
    logic               w_push;
    logic               w_frame_err;
    logic               w_rd_strobe;
    logic               w_bus_rd;
    logic               w_st_wr;
    logic               w_full;
    logic               w_empty;
    logic               w_do_pop;
    logic               w_do_push;
    logic               w_drop;
    logic [15:0]        w_rdata;

    assign w_rxd_s = sync2_q;

    // Receiver sequencing: half-bit start check, then one sample per bit time
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!w_rxd_s) begin
                    cnt_d   = C_HALF;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == 9'd0) begin
                    if (!w_rxd_s) begin
                        state_d = S_DATA;
                        cnt_d   = C_FULL;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            S_DATA: begin
                if (cnt_q == 9'd0) begin
                    shreg_d[idx_q] = w_rxd_s;
                    cnt_d          = C_FULL;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            default: begin
                if (cnt_q == 9'd0) begin
                    state_d     = S_IDLE;
                    w_push      = w_rxd_s;
                    w_frame_err = !w_rxd_s;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
        endcase
    end

    // Bus decode, FIFO bookkeeping and sticky flags (a set beats a clear)
    always_comb begin
        w_rd_strobe = !cs_b && rnw && a0;
        w_bus_rd    = !cs_b && rnw;
        w_st_wr     = !cs_b && !rnw && !a0;
        rd_d        = w_rd_strobe;
        w_full      = (count_q == C_CNT_W'(C_DEPTH));
        w_empty     = (count_q == '0);
        w_do_pop    = rd_q && !w_rd_strobe && !w_empty;
        w_do_push   = w_push && (!w_full || w_do_pop);
        w_drop      = w_push && w_full && !w_do_pop;
        ovr_d       = w_drop      || (ovr_q && !w_st_wr);
        frm_d       = w_frame_err || (frm_q && !w_st_wr);
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        if (w_do_push) begin
            wptr_d = (wptr_q == C_PTR_W'(C_DEPTH - 1)) ? '0 : wptr_q + C_PTR_W'(1);
        end
        if (w_do_pop) begin
            rptr_d = (rptr_q == C_PTR_W'(C_DEPTH - 1)) ? '0 : rptr_q + C_PTR_W'(1);
        end
        count_d = count_q + C_CNT_W'(w_do_push) - C_CNT_W'(w_do_pop);
        if (a0) begin
            w_rdata = w_empty ? 16'h0000 : {8'h00, mem_q[rptr_q]};
        end else begin
            w_rdata = {!w_empty, ovr_q, frm_q, 13'b0};
        end
    end

    assign data = w_bus_rd ? w_rdata : 16'hzzzz;

    // State register for synchronizer, receiver, FIFO pointers and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= 9'd0;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            rd_q    <= 1'b0;
            ovr_q   <= 1'b0;
            frm_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            rd_q    <= rd_d;
            ovr_q   <= ovr_d;
            frm_q   <= frm_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are only meaningful where count says so
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wptr_q] <= shreg_q;
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DIVISOR, default 32000000/115200 (277): clk cycles per bit time; legal range 4..511.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port data  inout  16  CPU data bus; driven only during a selected read, high-impedance otherwise.
REQ-005 SHALL have port a0  input  1  register select: 0 = status, 1 = receive data.
REQ-006 SHALL have port rnw  input  1  1 = read, 0 = write.
REQ-007 SHALL have port cs_b  input  1  active-low chip select.
REQ-008 SHALL have port rxd  input  1  asynchronous serial input, idle high, 8N1 LSB-first.

Function
REQ-009 SHALL pass rxd through a two-flop synchronizer; all receive logic SHALL use the synchronized value only.
REQ-010 SHALL implement receiver states IDLE, START, DATA and STOP, with a 9-bit bit-time counter and a 3-bit bit index.
REQ-011 IDLE: on synchronized rxd = 0, SHALL load counter with DIVISOR/2 - 1 and enter START.
REQ-012 START: at counter = 0, rxd = 0 SHALL enter DATA with counter = DIVISOR - 1 and bit index = 0; rxd = 1 SHALL treat the low level as a glitch and return to IDLE.
REQ-013 DATA: at each counter = 0, SHALL shift rxd into bit [index] of the shift register and reload the counter with DIVISOR - 1; after bit 7 SHALL enter STOP.
REQ-014 STOP: at counter = 0, rxd = 1 SHALL push the byte into the receive FIFO; rxd = 0 SHALL discard the byte and set the framing flag; both cases SHALL return to IDLE in the same cycle.
REQ-015 A pushed byte SHALL be visible to a status read in the clock cycle after the stop-bit sample.
REQ-016 Status read (cs_b = 0, rnw = 1, a0 = 0) SHALL drive {ready, overrun, framing, 13'b0}; ready = FIFO not empty.
REQ-017 Data read (cs_b = 0, rnw = 1, a0 = 1) SHALL drive {8'h00, FIFO head}; when the FIFO is empty it SHALL drive 16'h0000.
REQ-018 A data read SHALL pop the FIFO once, in the cycle after the read strobe deasserts, regardless of how long cs_b is held; a pop when empty SHALL be ignored.
REQ-019 A status write (cs_b = 0, rnw = 0, a0 = 0) SHALL clear the overrun and framing flags; data writes SHALL be ignored.
REQ-020 A push when the FIFO is full with no pop in the same cycle SHALL drop the new byte and set overrun; existing entries SHALL be unchanged.
REQ-021 A simultaneous push and pop on a full FIFO SHALL accept the new byte and SHALL NOT set overrun.
REQ-022 A flag set and a flag clear in the same cycle SHALL leave the flag set.
REQ-023 The FIFO SHALL be first-in first-out, with read and write pointers wrapping modulo depth.

Reset
REQ-024 Reset SHALL force state IDLE, empty the FIFO, clear overrun and framing, set the synchronizer flops to 1, and zero the counters.
REQ-025 Reset asserted mid-byte SHALL abandon the byte with no push and no flag set; a status read immediately after reset SHALL return 16'h0000.

Configuration
REQ-026 With UART_RX_FIFO_EN defined, the receive FIFO depth SHALL be 4 entries.
REQ-027 Without UART_RX_FIFO_EN, the FIFO SHALL reduce to a single holding register of depth 1 with identical status, overrun and pop semantics.

Verification
REQ-028 Bench (DIVISOR = 16): send 0xA5 -> status = 16'h8000 one cycle after the stop-bit sample; data read = 16'h00A5; next status = 16'h0000.
REQ-029 Bench: rxd low for 4 cycles, then high -> state returns to IDLE; status stays 16'h0000.
REQ-030 Bench: send 0x3C with stop bit = 0 -> status = 16'h2000, FIFO empty; status write -> status = 16'h0000.
REQ-031 Bench with UART_RX_FIFO_EN: send 0x01..0x05 with no reads -> status = 16'hC000; four data reads return 0x01, 0x02, 0x03, 0x04; without the macro, send two bytes -> reads return the first byte, then overrun (16'h4000) is set.
REQ-032 Bench: assert reset during DATA bit 3 -> status = 16'h0000 and no byte pushed; a following 0x5A is received correctly.
REQ-033 Bench: cs_b = 1, or rnw = 0 -> data is high-impedance on every cycle.
